// File: rtl/xgmii_rx_monitor.sv
// XGMII receive monitor: tracks Start/Terminate framing, checks length and control errors, counts frames.
// Define RX_OCTET_CNT_EN to add the 48-bit good-octet counter port octet_cnt.
module xgmii_rx_monitor #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1522
) (
   input  logic        xgmii_clk,
   input  logic        sys_rst,
   input  logic [63:0] xgmii_rxd,
   input  logic [7:0]  xgmii_rxc,
   input  logic        clear,
   output logic        rx_active,
   output logic        frame_pulse,
   output logic        err_pulse,
   output logic [31:0] frame_cnt,
   output logic [31:0] err_cnt,
   output logic [15:0] last_len
`ifdef RX_OCTET_CNT_EN
   ,
   output logic [47:0] octet_cnt
`endif
);

   localparam logic [7:0]  C_START = 8'hFB;
   localparam logic [7:0]  C_TERM  = 8'hFD;
   localparam logic [7:0]  C_ERR   = 8'hFE;
   localparam logic [15:0] L_MIN   = 16'(MIN_LEN);
   localparam logic [15:0] L_MAX   = 16'(MAX_LEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   state_t      w_rs_state;
   logic [15:0] r_len;
   logic [15:0] w_len_nxt;
   logic        r_bad;
   logic        w_bad_nxt;
   logic        w_rs_bad;
   logic        r_rx_active;
   logic        r_frame_pulse;
   logic        r_err_pulse;
   logic [31:0] r_frame_cnt;
   logic [31:0] r_err_cnt;
   logic [15:0] r_last_len;
   logic [7:0]  w_term;
   logic [7:0]  w_err;
   logic [7:0]  w_mask;
   logic        w_s0;
   logic        w_s4;
   logic [3:0]  w_term_pos;
   logic [3:0]  w_end_pos;
   logic [16:0] w_sum;
   logic [15:0] w_len_sum;
   logic        w_len_bad;
   logic        w_mark;
   logic        w_end;
   logic        w_end_bad;
   logic [15:0] w_end_len;

   assign w_s0 = xgmii_rxc[0] && (xgmii_rxd[7:0] == C_START);
   assign w_s4 = xgmii_rxc[4] && (xgmii_rxd[39:32] == C_START);

   // Per-lane control character decode
   always_comb begin
      w_term = 8'd0;
      w_err  = 8'd0;
      for (int i = 0; i < 8; i++) begin
         w_term[i] = xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == C_TERM);
         w_err[i]  = xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == C_ERR);
      end
   end

   // Where the current frame's octets stop in this word, and the resulting length
   always_comb begin
      w_term_pos = 4'd8;
      for (int i = 7; i >= 0; i--) begin
         w_term_pos = w_term[i] ? 4'(i) : w_term_pos;
      end
      if (w_s0) begin
         w_end_pos = 4'd0;
      end else if (w_s4 && (w_term_pos > 4'd4)) begin
         w_end_pos = 4'd4;
      end else begin
         w_end_pos = w_term_pos;
      end
      w_mask = 8'd0;
      for (int i = 0; i < 8; i++) begin
         w_mask[i] = (4'(i) < w_end_pos);
      end
      // Any control inside the frame region is a bad mark; a Terminate can only sit at or past w_end_pos
      w_mark    = |(xgmii_rxc & w_mask);
      w_sum     = {1'b0, r_len} + {13'd0, w_end_pos};
      w_len_sum = w_sum[16] ? 16'hFFFF : w_sum[15:0];
      w_len_bad = (w_len_sum < L_MIN) || (w_len_sum > L_MAX);
      w_rs_state = w_s0 ? S_DATA : S_PRE;
      w_rs_bad   = w_s0 ? (|w_err[7:1]) : (|w_err[7:5]);
   end

   // Frame FSM next state, length accumulation and end-of-frame classification
   always_comb begin
      w_state_nxt = r_state;
      w_len_nxt   = r_len;
      w_bad_nxt   = r_bad;
      w_end       = 1'b0;
      w_end_bad   = 1'b0;
      w_end_len   = r_len;
      case (r_state)
         S_IDLE: begin
            if (w_s0 || w_s4) begin
               w_state_nxt = w_rs_state;
               w_len_nxt   = 16'd0;
               w_bad_nxt   = w_rs_bad;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_PRE: begin
            if (w_s0 || w_s4) begin
               w_end       = 1'b1;
               w_end_bad   = 1'b1;
               w_end_len   = r_len;
               w_state_nxt = w_rs_state;
               w_len_nxt   = 16'd0;
               w_bad_nxt   = w_rs_bad;
            end else begin
               // Lanes 0-3 finish the preamble and SFD; lanes 4-7 are the first data octets
               w_state_nxt = S_DATA;
               w_len_nxt   = 16'd4;
               w_bad_nxt   = r_bad | (|w_err) | (|xgmii_rxc[7:4]);
            end
         end
         S_DATA: begin
            if (w_s0 || (w_s4 && (w_term_pos > 4'd4))) begin
               w_end       = 1'b1;
               w_end_bad   = 1'b1;
               w_end_len   = w_len_sum;
               w_state_nxt = w_rs_state;
               w_len_nxt   = 16'd0;
               w_bad_nxt   = w_rs_bad;
            end else if (w_term_pos != 4'd8) begin
               w_end       = 1'b1;
               w_end_bad   = r_bad | w_mark | w_len_bad;
               w_end_len   = w_len_sum;
               w_state_nxt = S_IDLE;
               w_len_nxt   = 16'd0;
               w_bad_nxt   = 1'b0;
            end else begin
               w_len_nxt = w_len_sum;
               w_bad_nxt = r_bad | w_mark;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_len_nxt   = 16'd0;
            w_bad_nxt   = 1'b0;
         end
      endcase
   end

   // FSM state, frame accumulators and per-frame output strobes
   always_ff @(posedge xgmii_clk) begin
      if (sys_rst) begin
         r_state       <= S_IDLE;
         r_len         <= 16'd0;
         r_bad         <= 1'b0;
         r_rx_active   <= 1'b0;
         r_frame_pulse <= 1'b0;
         r_err_pulse   <= 1'b0;
         r_last_len    <= 16'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_len         <= w_len_nxt;
         r_bad         <= w_bad_nxt;
         r_rx_active   <= (r_state != S_IDLE);
         r_frame_pulse <= w_end && !w_end_bad;
         r_err_pulse   <= w_end && w_end_bad;
         r_last_len    <= w_end ? w_end_len : r_last_len;
      end
   end

   // Event counters; clear takes priority over a coincident increment
   always_ff @(posedge xgmii_clk) begin
      if (sys_rst || clear) begin
         r_frame_cnt <= 32'd0;
         r_err_cnt   <= 32'd0;
      end else begin
         r_frame_cnt <= r_frame_cnt + {31'd0, (w_end && !w_end_bad)};
         r_err_cnt   <= r_err_cnt + {31'd0, (w_end && w_end_bad)};
      end
   end

`ifdef RX_OCTET_CNT_EN
   logic [47:0] r_octet_cnt;

   // Good-frame octet total
   always_ff @(posedge xgmii_clk) begin
      if (sys_rst || clear) begin
         r_octet_cnt <= 48'd0;
      end else if (w_end && !w_end_bad) begin
         r_octet_cnt <= r_octet_cnt + {32'd0, w_end_len};
      end else begin
         r_octet_cnt <= r_octet_cnt;
      end
   end

   assign octet_cnt = r_octet_cnt;
`endif

   assign rx_active   = r_rx_active;
   assign frame_pulse = r_frame_pulse;
   assign err_pulse   = r_err_pulse;
   assign frame_cnt   = r_frame_cnt;
   assign err_cnt     = r_err_cnt;
   assign last_len    = r_last_len;

endmodule

// File: tb/tb_xgmii_rx_monitor.sv
// Bench for xgmii_rx_monitor: builds an octet stream of frames, predicts per-word outcomes from frame construction.
// Checks octet_cnt too when RX_OCTET_CNT_EN is defined.
module tb_xgmii_rx_monitor;
   localparam int MAXW = 4096;

   logic        clk = 1'b0;
   logic        sys_rst;
   logic        clear;
   logic [63:0] rxd;
   logic [7:0]  rxc;
   logic        rx_active;
   logic        frame_pulse;
   logic        err_pulse;
   logic [31:0] frame_cnt;
   logic [31:0] err_cnt;
   logic [15:0] last_len;
`ifdef RX_OCTET_CNT_EN
   logic [47:0] octet_cnt;
`endif

   always #5 clk = ~clk;

   xgmii_rx_monitor dut (
      .xgmii_clk   (clk),
      .sys_rst     (sys_rst),
      .xgmii_rxd   (rxd),
      .xgmii_rxc   (rxc),
      .clear       (clear),
      .rx_active   (rx_active),
      .frame_pulse (frame_pulse),
      .err_pulse   (err_pulse),
      .frame_cnt   (frame_cnt),
      .err_cnt     (err_cnt),
      .last_len    (last_len)
`ifdef RX_OCTET_CNT_EN
      ,
      .octet_cnt   (octet_cnt)
`endif
   );

   // Stream of lanes {is_control, octet} and per-word expectations
   logic [8:0]  lq[$];
   int          ev_type[MAXW];
   int          ev_len[MAXW];
   bit          act[MAXW];
   bit          clr[MAXW];
   int          last_t_word;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_frames;
   logic [31:0] m_errs;
   logic [15:0] m_len;
   logic [47:0] m_oct;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stream();
      lq.delete();
      for (int i = 0; i < MAXW; i++) begin
         ev_type[i] = 0;
         ev_len[i]  = 0;
         act[i]     = 1'b0;
         clr[i]     = 1'b0;
      end
   endtask

   task automatic pad_to(input int lane);
      while ((lq.size() % 8) != lane) lq.push_back({1'b1, 8'h07});
   endtask

   task automatic push_preamble(output int sw);
      sw = lq.size() / 8;
      lq.push_back({1'b1, 8'hFB});
      repeat (6) lq.push_back({1'b0, 8'h55});
      lq.push_back({1'b0, 8'hD5});
   endtask

   task automatic push_data(input int len, input int err_at);
      for (int i = 0; i < len; i++) begin
         if (i == err_at) lq.push_back({1'b1, 8'hFE});
         else lq.push_back({1'b0, 8'($urandom_range(0, 255))});
      end
   endtask

   // Frame with Terminate; outcome follows purely from length and injected error
   task automatic add_frame(input int len, input int lane, input int err_at);
      int sw;
      int tw;
      bit bad;
      pad_to(lane);
      push_preamble(sw);
      push_data(len, err_at);
      tw = lq.size() / 8;
      lq.push_back({1'b1, 8'hFD});
      bad = (err_at >= 0) || (len < 64) || (len > 1522);
      ev_type[tw] = bad ? 2 : 1;
      ev_len[tw]  = len;
      for (int w = sw; w < tw; w++) act[w] = 1'b1;
      last_t_word = tw;
      while ((lq.size() % 8) != 0) lq.push_back({1'b0, 8'($urandom_range(0, 255))});
      for (int j = 0; j < 8; j++) lq.push_back((j == 2 || j == 6) ? {1'b1, 8'hFB} : {1'b1, 8'h07});
   endtask

   // Frame cut off by a lane-0 Start in the next word; caller must follow with add_frame(..., 0, ...)
   task automatic add_abort(input int len);
      int sw;
      int tw;
      pad_to(0);
      push_preamble(sw);
      push_data(len, -1);
      tw = lq.size() / 8;
      ev_type[tw] = 2;
      ev_len[tw]  = len;
      for (int w = sw; w < tw; w++) act[w] = 1'b1;
   endtask

   task automatic run_stream();
      bit         prev_act;
      int         nw;
      logic [8:0] ln;
      prev_act = 1'b0;
      pad_to(0);
      repeat (8) lq.push_back({1'b1, 8'h07});
      nw = lq.size() / 8;
      for (int k = 0; k < nw; k++) begin
         @(negedge clk);
         for (int j = 0; j < 8; j++) begin
            ln = lq[8*k + j];
            rxd[8*j +: 8] = ln[7:0];
            rxc[j]        = ln[8];
         end
         clear = clr[k];
         @(posedge clk);
         #1;
         if (ev_type[k] == 1) begin
            m_frames = m_frames + 32'd1;
            m_oct    = m_oct + 48'(ev_len[k]);
         end
         if (ev_type[k] == 2) m_errs = m_errs + 32'd1;
         if (ev_type[k] != 0) m_len = 16'(ev_len[k]);
         if (clr[k]) begin
            m_frames = 32'd0;
            m_errs   = 32'd0;
            m_oct    = 48'd0;
         end
         chk("frame_pulse", 64'(frame_pulse), 64'(ev_type[k] == 1));
         chk("err_pulse", 64'(err_pulse), 64'(ev_type[k] == 2));
         chk("frame_cnt", 64'(frame_cnt), 64'(m_frames));
         chk("err_cnt", 64'(err_cnt), 64'(m_errs));
         chk("last_len", 64'(last_len), 64'(m_len));
         chk("rx_active", 64'(rx_active), 64'(prev_act));
`ifdef RX_OCTET_CNT_EN
         chk("octet_cnt", 64'(octet_cnt), 64'(m_oct));
`endif
         prev_act = act[k];
      end
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      int len;
      int err;
      sys_rst  = 1'b1;
      clear    = 1'b0;
      rxd      = {8{8'h07}};
      rxc      = 8'hFF;
      m_frames = 32'd0;
      m_errs   = 32'd0;
      m_len    = 16'd0;
      m_oct    = 48'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_frame_pulse", 64'(frame_pulse), 64'd0);
      chk("rst_err_pulse", 64'(err_pulse), 64'd0);
      chk("rst_rx_active", 64'(rx_active), 64'd0);
      chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);
      chk("rst_last_len", 64'(last_len), 64'd0);
      @(negedge clk);
      sys_rst = 1'b0;

      clear_stream();
      add_frame(64, 0, -1);
      add_frame(60, 4, -1);
      add_frame(100, 0, 11);
      add_frame(1600, 0, -1);
      add_frame(1522, 4, -1);
      add_abort(40);
      add_frame(64, 0, -1);
      add_frame(63, 0, -1);
      add_frame(1523, 4, -1);
      add_frame(64, 4, -1);
      add_frame(1522, 0, -1);
      add_frame(65, 4, 2);
      add_frame(80, 0, -1);
      clr[last_t_word] = 1'b1;
      add_frame(90, 4, -1);
      clr[last_t_word + 1] = 1'b1;
      for (int f = 0; f < 16; f++) begin
         len = int'($urandom_range(40, 200));
         err = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         if ($urandom_range(0, 4) == 0) begin
            add_abort(8 * int'($urandom_range(1, 20)));
            add_frame(len, 0, err);
         end else begin
            add_frame(len, 4 * int'($urandom_range(0, 1)), err);
         end
      end
      run_stream();

      // Reset in the middle of a frame discards it silently
      @(negedge clk);
      rxd = 64'hD5555555_555555FB;
      rxc = 8'h01;
      repeat (2) begin
         @(negedge clk);
         rxd = {$urandom, $urandom};
         rxc = 8'h00;
      end
      @(posedge clk);
      #1;
      chk("mid_rx_active", 64'(rx_active), 64'd1);
      @(negedge clk);
      sys_rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_frame_pulse", 64'(frame_pulse), 64'd0);
      chk("mrst_err_pulse", 64'(err_pulse), 64'd0);
      chk("mrst_rx_active", 64'(rx_active), 64'd0);
      chk("mrst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("mrst_err_cnt", 64'(err_cnt), 64'd0);
      chk("mrst_last_len", 64'(last_len), 64'd0);
`ifdef RX_OCTET_CNT_EN
      chk("mrst_octet_cnt", 64'(octet_cnt), 64'd0);
`endif
      @(negedge clk);
      sys_rst = 1'b0;
      rxd = 64'h07070707_070707FD;
      rxc = 8'hFF;
      @(posedge clk);
      #1;
      @(negedge clk);
      rxd = {8{8'h07}};
      @(posedge clk);
      #1;
      chk("post_rst_frame_pulse", 64'(frame_pulse), 64'd0);
      chk("post_rst_err_pulse", 64'(err_pulse), 64'd0);
      chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("post_rst_err_cnt", 64'(err_cnt), 64'd0);

      m_frames = 32'd0;
      m_errs   = 32'd0;
      m_len    = 16'd0;
      m_oct    = 48'd0;
      clear_stream();
      add_frame(64, 0, -1);
      add_frame(70, 4, -1);
      add_frame(50, 0, -1);
      run_stream();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/xgmii_rx_monitor.md
XGMII_RX_MONITOR -- requirements
Module: xgmii_rx_monitor

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, meaning the smallest good frame length in octets, FCS included.
REQ-002 SHALL have parameter MAX_LEN, default 1522, meaning the largest good frame length in octets, FCS included.
REQ-003 SHALL have port xgmii_clk, input, 1 bit: the 156.25 MHz clock; the block has one clock.
REQ-004 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port xgmii_rxd, input, 64 bits: receive data; lane i = bits [8i+7:8i].
REQ-006 SHALL have port xgmii_rxc, input, 8 bits: receive control; bit i set marks lane i as a control character.
REQ-007 SHALL have port clear, input, 1 bit: a one-cycle pulse that zeroes all counters.
REQ-008 SHALL have port rx_active, output, 1 bit: high while a frame is in progress.
REQ-009 SHALL have port frame_pulse, output, 1 bit: one-cycle strobe on each good frame.
REQ-010 SHALL have port err_pulse, output, 1 bit: one-cycle strobe on each bad frame.
REQ-011 SHALL have port frame_cnt, output, 32 bits: good-frame count.
REQ-012 SHALL have port err_cnt, output, 32 bits: bad-frame count.
REQ-013 SHALL have port last_len, output, 16 bits: length of the most recently ended frame.
REQ-014 SHALL have port octet_cnt, output, 48 bits: total good-frame octets; this port exists only under RX_OCTET_CNT_EN.

Function
REQ-015 SHALL decode control characters only where the matching xgmii_rxc bit is set: Start=0xFB, Terminate=0xFD, Error=0xFE, Idle=0x07.
REQ-016 SHALL use the state machine IDLE, PRE, DATA:
- IDLE to DATA: Start in lane 0.
- IDLE to PRE: Start in lane 4.
- PRE to DATA: on the next word, unconditionally.
- DATA to IDLE: on Terminate.
REQ-017 SHALL ignore Start in lanes 1-3 or 5-7 while in IDLE.
REQ-018 SHALL define frame length as the octets from the first octet after the SFD up to the octet before Terminate.
- Lane-0 start: data begins at lane 0 of the next word.
- Lane-4 start: data begins at lane 4 of the PRE+1 word.
- Preamble and SFD contents SHALL NOT be checked.
REQ-019 SHALL add the number of data lanes of each word to a 16-bit length accumulator; the accumulator saturates at 0xFFFF.
REQ-020 SHALL classify a frame as bad if any of the following holds:
- the length is below MIN_LEN or above MAX_LEN;
- an Error character appears anywhere from Start through Terminate;
- any control character other than Terminate appears in DATA before Terminate.
REQ-021 SHALL treat a Start received in DATA or PRE as follows:
- the current frame ends as bad;
- the same word begins a new frame per REQ-016.
REQ-022 SHALL take a control character other than Terminate in DATA as a mark only: the frame is marked bad and stays in DATA until Terminate or Start.
REQ-023 SHALL, one cycle after the word holding Terminate:
- pulse frame_pulse or err_pulse (exactly one of them);
- increment the matching counter;
- update last_len.
REQ-024 SHALL ignore data lanes after Terminate in the same word.
REQ-025 SHALL drive rx_active high in PRE and DATA, registered, one cycle after the state change.
REQ-026 SHALL wrap frame_cnt and err_cnt modulo 2^32.
REQ-027 SHALL let clear win when clear coincides with an increment: the counter reads 0 the next cycle and that event is lost; pulses and last_len are unaffected.
REQ-028 SHALL drive all outputs from registers.

Reset
REQ-029 SHALL, while sys_rst is high at a xgmii_clk edge:
- force IDLE;
- zero the length accumulator, all counters and last_len;
- drive rx_active, frame_pulse and err_pulse low.
REQ-030 SHALL discard a frame in progress when sys_rst is asserted mid-frame, with no pulse; the next frame is accepted only from a fresh Start after release.

Configuration
REQ-031 SHALL include octet_cnt only when RX_OCTET_CNT_EN is defined.
- With the macro: octet_cnt adds last_len on each good frame, wraps modulo 2^48, and is zeroed by sys_rst and clear.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Verification
REQ-032 SHALL cover: a 64-octet frame with lane-0 Start, Terminate in lane 0 of the word after the last data word -> frame_pulse once, frame_cnt=1, last_len=64, octet_cnt=64.
REQ-033 SHALL cover: a 60-octet frame with lane-4 Start -> err_pulse once, err_cnt=1, last_len=60, octet_cnt unchanged.
REQ-034 SHALL cover: a 100-octet frame with 0xFE in lane 3 of the second data word -> err_cnt=1, frame_cnt=0.
REQ-035 SHALL cover: a frame of 1600 octets -> err_cnt=1; a frame of 1522 octets -> frame_cnt=1, last_len=1522.
REQ-036 SHALL cover: a Start in lane 0 while in DATA after 40 octets, then a valid 64-octet frame -> err_cnt=1, frame_cnt=1, last_len=64.
REQ-037 SHALL cover two reset/clear cases:
- clear asserted in the same cycle as frame_pulse -> frame_cnt=0 the next cycle;
- sys_rst asserted mid-frame -> no pulse, all counters 0.
